fma_scheduler: RTL and testbench
================================

FMA_SCHEDULER -- requirements
Module: fma_scheduler

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing one FMA datapath.
REQ-002 Parameter LAT, default 2: fixed FMA pipeline latency in enabled cycles, range 1..8.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 enable  in  1  global run; low = freeze issue, tag pipeline and FMA.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_ready  out  NREQ  one-hot grant; handshake completes when valid&ready.
REQ-008 req_a, req_b  in  NREQ*8  operand bytes, requester i at [8*i +: 8].
REQ-009 req_c  in  NREQ*16  addend, requester i at [16*i +: 16].
REQ-010 fma_en  out  1  datapath clock enable (= enable).
REQ-011 fma_a, fma_b  out  8  operands to FMA; fma_c  out  16  addend.
REQ-012 fma_out  in  16  FMA result, valid LAT enabled cycles after issue.
REQ-013 rsp_valid  out  1; rsp_id  out  clog2(NREQ); rsp_data  out  16  response port, no backpressure.
REQ-014 busy  out  1  high while any op is in flight.
REQ-015 grant_count  out  NREQ*8  per-requester completed-issue counters.

Function
REQ-016 Arbitration round-robin: pointer P (0..NREQ-1); search order P, P+1, ... wrapping; first valid requester granted.
REQ-017 req_ready purely combinational from req_valid, P and enable; at most one bit high; all low when enable=0 or reset=1.
REQ-018 At most one issue per cycle; issue = any valid&ready.
REQ-019 On issue to requester g: P <= (g+1) mod NREQ; without issue P holds.
REQ-020 fma_a/b/c drive the granted requester's operands in the issue cycle; with no issue, drive zeros.
REQ-021 Tag pipeline: LAT stages of {valid, id}; stage 0 loads {issue, g} each enabled cycle; stages shift only when enable=1.
REQ-022 rsp_valid = last stage valid AND enable; rsp_id = last stage id; rsp_data = fma_out; combinational from pipeline state.
REQ-023 Latency: op issued at enabled cycle k responds in enabled cycle k+LAT; disabled cycles do not count.
REQ-024 Throughput: one op per enabled cycle sustained; back-to-back ops from same or different requesters allowed.
REQ-025 Ordering: responses exit in issue order; no reordering, no loss while enable toggles.
REQ-026 busy = OR of all tag stage valids.
REQ-027 grant_count[i] increments by 1 on each issue to i; wraps 255 -> 0.
REQ-028 Single requester continuously valid receives a grant every enabled cycle.
REQ-029 req_valid dropped without grant: no state effect; operands not captured.

Reset
REQ-030 Reset: P=0, all tag stages invalid, grant_count all 0, rsp_valid=0, busy=0, req_ready=0, fma_a/b/c=0.
REQ-031 Reset mid-operation discards in-flight ops; no response emitted for them, including in the reset cycle.
REQ-032 Reset overrides enable and req_valid in the same cycle.

Verification
REQ-033 NREQ=3, LAT=2, all valid continuously, enable=1 -> grants 0,1,2,0,1,2; rsp_id sequence identical, delayed 2 cycles.
REQ-034 Only req 1 valid, a=3,b=4,c=5, FMA model a*b+c -> ready[1] every cycle; rsp_data=17, rsp_id=1, two cycles after each issue.
REQ-035 Issue op, drop enable 3 cycles after issue cycle -> no rsp_valid while low; response one enabled cycle after re-enable; busy high throughout.
REQ-036 Two ops in flight, assert reset one cycle -> no responses ever appear; busy=0, P=0, grant_count=0 after reset.
REQ-037 Req 0 issued 256 times -> grant_count[0] returns to 0; other counters unchanged.
REQ-038 Req 2 granted, then req 0 and 2 valid -> req 0 granted next (pointer wrap).

Source files
------------

// File: rtl/fma_scheduler.sv
// fma_scheduler
//   Round-robin front end for one shared, fixed-latency FMA datapath.
//   Requesters post {a, b, c}. One of them is granted each enabled cycle.
//   Its operands go straight to the FMA. A tag pipeline that matches the FMA
//   latency carries {valid, id}, so each result comes back with the id of
//   the requester that issued it.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   enable           global run; low freezes issue, tag pipeline and FMA
//   req_valid        [NREQ]     per-requester request
//   req_ready        [NREQ]     one-hot grant (combinational)
//   req_a, req_b     [NREQ*8]   operand bytes, requester i at [8*i +: 8]
//   req_c            [NREQ*16]  addend, requester i at [16*i +: 16]
//   fma_en           FMA clock enable (= enable)
//   fma_a/b/c        operands of the granted requester, zero when idle
//   fma_out          FMA result, valid LAT enabled cycles after issue
//   rsp_valid/id/data  response port, no backpressure
//   busy             any op in flight
//   grant_count      [NREQ*8]   per-requester issue counters, wrapping
module fma_scheduler #(
  parameter int NREQ = 3,
  parameter int LAT  = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*8-1:0]  req_a,
  input  logic [NREQ*8-1:0]  req_b,
  input  logic [NREQ*16-1:0] req_c,
  output logic               fma_en,
  output logic [7:0]         fma_a,
  output logic [7:0]         fma_b,
  output logic [15:0]        fma_c,
  input  logic [15:0]        fma_out,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_data,
  output logic               busy,
  output logic [NREQ*8-1:0]  grant_count
);

  logic [IDW-1:0] ptr_reg;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic           issue;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] scan_idx;

  logic [7:0]     a_arr [NREQ];
  logic [7:0]     b_arr [NREQ];
  logic [15:0]    c_arr [NREQ];

  logic [LAT-1:0] tag_valid_reg;
  logic [IDW-1:0] tag_id_reg [LAT];

  // Unpack the flat operand buses so the mux can select them by requester id.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[8*gi +: 8];
      assign b_arr[gi] = req_b[8*gi +: 8];
      assign c_arr[gi] = req_c[16*gi +: 16];
    end
  endgenerate

  // Search starts at the pointer and wraps. The first valid requester wins.
  // The index is computed one bit wider so the wrap also works when NREQ is
  // not a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ))
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (enable && !reset && grant_found)
      req_ready = NREQ'(1) << grant_id;
  end

  assign issue  = |req_ready;
  assign fma_en = enable;

  always_comb begin
    fma_a = '0;
    fma_b = '0;
    fma_c = '0;
    if (issue) begin
      fma_a = a_arr[grant_id];
      fma_b = b_arr[grant_id];
      fma_c = c_arr[grant_id];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr_reg <= '0;
    else if (issue)
      ptr_reg <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
  end

  // The tag pipeline advances only on enabled cycles, in lockstep with the
  // FMA. The last stage therefore lines up with fma_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_reg <= '0;
      for (int s = 0; s < LAT; s++)
        tag_id_reg[s] <= '0;
    end else if (enable) begin
      for (int s = LAT-1; s > 0; s--) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
      tag_valid_reg[0] <= issue;
      tag_id_reg[0]    <= grant_id;
    end
  end

  // Masking with reset keeps ops that are being discarded from showing a
  // response in the reset cycle itself.
  assign rsp_valid = tag_valid_reg[LAT-1] & enable & ~reset;
  assign rsp_id    = tag_id_reg[LAT-1];
  assign rsp_data  = fma_out;
  assign busy      = |tag_valid_reg;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_count
      logic [7:0] count_reg;
      always_ff @(posedge clk) begin
        if (reset)
          count_reg <= '0;
        else if (issue && grant_id == IDW'(gi))
          count_reg <= count_reg + 8'd1;
      end
      assign grant_count[8*gi +: 8] = count_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fma_scheduler.sv
module tb_fma_scheduler;
  localparam int NREQ = 3;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*16-1:0] req_c;
  logic              fma_en;
  logic [7:0]        fma_a;
  logic [7:0]        fma_b;
  logic [15:0]       fma_c;
  logic [15:0]       fma_out;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;
  logic              busy;
  logic [NREQ*8-1:0] grant_count;

  fma_scheduler #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .fma_en(fma_en), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_out(fma_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .grant_count(grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External FMA: a*b+c with LAT enabled cycles of latency.
  logic [15:0] fma_pipe [LAT];
  initial for (int s = 0; s < LAT; s++) fma_pipe[s] = '0;
  always @(posedge clk) begin
    if (fma_en) begin
      for (int s = LAT-1; s > 0; s--) fma_pipe[s] <= fma_pipe[s-1];
      fma_pipe[0] <= 16'(32'(fma_a) * 32'(fma_b) + 32'(fma_c));
    end
  end
  assign fma_out = fma_pipe[LAT-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a round-robin pointer, a count of enabled cycles and a
  // queue of in-flight ops. Each op records the enabled-cycle index at which
  // its response is due.
  typedef struct { int id; logic [15:0] data; int due; } op_t;
  op_t m_q[$];
  int  m_ptr = 0;
  int  m_cnt [NREQ];
  int  ecount = 0;
  initial for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;

  // Called at the negedge. It compares every output against the model and
  // then advances the model by one clock.
  task automatic model_step();
    logic [NREQ-1:0]   er;
    logic              erv;
    int                g;
    logic [7:0]        ea, eb;
    logic [15:0]       ec;
    logic [NREQ*8-1:0] egc;
    er = '0; erv = 1'b0; g = -1; ea = '0; eb = '0; ec = '0;
    if (!reset && enable) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && ((req_valid >> idx) & 1) != 0) g = idx;
      end
      if (g >= 0) begin
        er = NREQ'(1) << g;
        ea = 8'(req_a >> (8*g));
        eb = 8'(req_b >> (8*g));
        ec = 16'(req_c >> (16*g));
      end
      if (m_q.size() > 0 && m_q[0].due == ecount) erv = 1'b1;
    end
    egc = '0;
    for (int i = 0; i < NREQ; i++) egc = egc | (NREQ*8)'((m_cnt[i] & 255) << (8*i));
    check("ready", 32'(req_ready), 32'(er));
    check("rsp_valid", 32'(rsp_valid), 32'(erv));
    if (erv) begin
      check("rsp_id", 32'(rsp_id), 32'(m_q[0].id));
      check("rsp_data", 32'(rsp_data), 32'(m_q[0].data));
    end
    check("busy", 32'(busy), 32'(m_q.size() != 0));
    check("fma_a", 32'(fma_a), 32'(ea));
    check("fma_b", 32'(fma_b), 32'(eb));
    check("fma_c", 32'(fma_c), 32'(ec));
    check("grant_count", 32'(grant_count), 32'(egc));
    if (reset) begin
      m_q.delete();
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    end else if (enable) begin
      if (erv) void'(m_q.pop_front());
      if (g >= 0) begin
        op_t op;
        op.id   = g;
        op.data = 16'(int'(ea) * int'(eb) + int'(ec));
        op.due  = ecount + LAT;
        m_q.push_back(op);
        m_ptr = (g + 1) % NREQ;
        m_cnt[g] = (m_cnt[g] + 1) % 256;
      end
      ecount++;
    end
  endtask

  task automatic tick_begin(input logic en, input logic rst, input logic [NREQ-1:0] v);
    enable = en; reset = rst; req_valid = v;
    @(negedge clk);
  endtask

  task automatic tick_end();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic en, input logic rst, input logic [NREQ-1:0] v);
    tick_begin(en, rst, v);
    tick_end();
  endtask

  typedef struct {
    logic            en;
    logic            rst;
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] ready;
    logic            rv;
    logic [IDW-1:0]  id;
  } vec_t;
  vec_t tbl [18];

  initial begin
    // Hand-derived sequence: a reset, then six cycles with all requesters
    // valid, then the pointer wrap, then enable gaps.
    tbl[0]  = '{1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 3'b111, 3'b001, 1'b0, 2'd0};
    tbl[2]  = '{1'b1, 1'b0, 3'b111, 3'b010, 1'b0, 2'd0};
    tbl[3]  = '{1'b1, 1'b0, 3'b111, 3'b100, 1'b1, 2'd0};
    tbl[4]  = '{1'b1, 1'b0, 3'b111, 3'b001, 1'b1, 2'd1};
    tbl[5]  = '{1'b1, 1'b0, 3'b111, 3'b010, 1'b1, 2'd2};
    tbl[6]  = '{1'b1, 1'b0, 3'b111, 3'b100, 1'b1, 2'd0};
    tbl[7]  = '{1'b1, 1'b0, 3'b100, 3'b100, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 1'b0, 3'b101, 3'b001, 1'b1, 2'd2};
    tbl[9]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 2'd2};
    tbl[10] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 2'd0};
    tbl[11] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 2'd0};
    tbl[13] = '{1'b1, 1'b0, 3'b010, 3'b010, 1'b0, 2'd0};
    tbl[14] = '{1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 2'd0};
    tbl[15] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0};
    tbl[16] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 2'd1};
    tbl[17] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd0};

    enable = 1'b0; reset = 1'b1; req_valid = '0;
    req_a = 24'($urandom); req_b = 24'($urandom); req_c = 48'({$urandom, $urandom});
    tick(1'b0, 1'b1, 3'b000);

    for (int i = 0; i < 18; i++) begin
      tick_begin(tbl[i].en, tbl[i].rst, tbl[i].v);
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      check($sformatf("tbl%0d_rv", i), 32'(rsp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) check($sformatf("tbl%0d_id", i), 32'(rsp_id), 32'(tbl[i].id));
      tick_end();
    end

    // Only requester 1 valid, with a=3, b=4, c=5: a grant every cycle and
    // a response of 17 two cycles after each issue.
    tick(1'b1, 1'b1, 3'b000);
    req_a = 24'h000300; req_b = 24'h000400; req_c = 48'h0000_0005_0000;
    for (int i = 0; i < 6; i++) begin
      tick_begin(1'b1, 1'b0, 3'b010);
      check("single_ready", 32'(req_ready), 32'h2);
      if (i >= LAT) begin
        check("single_rv", 32'(rsp_valid), 32'h1);
        check("single_id", 32'(rsp_id), 32'h1);
        check("single_data", 32'(rsp_data), 32'd17);
      end
      tick_end();
    end

    // Freeze for three cycles right after an issue. The response waits for
    // two enabled cycles and busy stays high throughout.
    tick(1'b1, 1'b1, 3'b000);
    tick(1'b1, 1'b0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      tick_begin(1'b0, 1'b0, 3'b000);
      check("freeze_rv", 32'(rsp_valid), 32'h0);
      check("freeze_busy", 32'(busy), 32'h1);
      tick_end();
    end
    tick_begin(1'b1, 1'b0, 3'b000);
    check("resume1_rv", 32'(rsp_valid), 32'h0);
    check("resume1_busy", 32'(busy), 32'h1);
    tick_end();
    tick_begin(1'b1, 1'b0, 3'b000);
    check("resume2_rv", 32'(rsp_valid), 32'h1);
    check("resume2_id", 32'(rsp_id), 32'h1);
    check("resume2_data", 32'(rsp_data), 32'd17);
    tick_end();

    // Reset with two ops in flight: no responses, and the state is cleared.
    tick(1'b1, 1'b0, 3'b111);
    tick(1'b1, 1'b0, 3'b111);
    tick_begin(1'b1, 1'b1, 3'b111);
    check("rst_cycle_rv", 32'(rsp_valid), 32'h0);
    check("rst_cycle_ready", 32'(req_ready), 32'h0);
    tick_end();
    tick_begin(1'b1, 1'b0, 3'b000);
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_count", 32'(grant_count), 32'h0);
    check("post_rst_rv", 32'(rsp_valid), 32'h0);
    tick_end();
    for (int i = 0; i < 3; i++) begin
      tick_begin(1'b1, 1'b0, 3'b000);
      check("post_rst_rv", 32'(rsp_valid), 32'h0);
      tick_end();
    end
    tick_begin(1'b1, 1'b0, 3'b111);
    check("post_rst_ptr", 32'(req_ready), 32'h1);
    tick_end();

    // 256 issues to requester 0 wrap its counter back to zero.
    tick(1'b1, 1'b1, 3'b000);
    for (int i = 0; i < 256; i++) begin
      req_a = 24'($urandom); req_b = 24'($urandom); req_c = 48'({$urandom, $urandom});
      tick(1'b1, 1'b0, 3'b001);
    end
    tick_begin(1'b1, 1'b0, 3'b000);
    check("wrap_count", 32'(grant_count), 32'h0);
    tick_end();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      req_a = 24'($urandom); req_b = 24'($urandom); req_c = 48'({$urandom, $urandom});
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0), 3'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
